// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// The master drives operands and out_ready; the slave returns in_ready and the result beat.
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             ovf;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/addsub_pipe.sv
// Two-stage signed add/sub/accumulate pipeline with valid/ready flow control.
// S1 holds captured operands; the result is computed on the S1->S2 transfer and held in S2.
module addsub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter bit          SAT   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_ADD  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_full_q, s1_full_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  op_e              mode_q, mode_d;
  logic             s2_full_q, s2_full_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s1_adv;
  logic             in_ready;
  logic             accept;
  logic [WIDTH:0]   exact;
  logic             res_ovf;
  logic [WIDTH-1:0] res;

  // One extra bit of headroom holds the exact signed result of any op.
  always_comb begin
    logic [WIDTH:0] a_x, b_x, acc_x;
    a_x   = {a_q[WIDTH-1], a_q};
    b_x   = {b_q[WIDTH-1], b_q};
    acc_x = {acc_q[WIDTH-1], acc_q};
    exact = a_x;
    case (mode_q)
      OP_SUB:  exact = a_x - b_x;
      OP_ADD:  exact = a_x + b_x;
      OP_ACC:  exact = acc_x + a_x;
      default: exact = a_x;
    endcase
    res_ovf = exact[WIDTH] ^ exact[WIDTH-1];
    res     = exact[WIDTH-1:0];
    if (SAT && res_ovf) begin
      res = exact[WIDTH] ? MIN_NEG : MAX_POS;
    end
  end

  always_comb begin
    s1_adv   = s1_full_q && (!s2_full_q || bus.out_ready);
    in_ready = rst_n && (!s1_full_q || s1_adv);
    accept   = bus.in_valid && in_ready;
  end

  // S2 is consumed before it is refilled, so a same-cycle pop and push keeps it full.
  always_comb begin
    s1_full_d = s1_full_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    s2_full_d = s2_full_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    if (!rst_n) begin
      s1_full_d = 1'b0;
      a_d       = '0;
      b_d       = '0;
      mode_d    = OP_SUB;
      s2_full_d = 1'b0;
      y_d       = '0;
      ovf_d     = 1'b0;
      acc_d     = '0;
    end else begin
      if (s2_full_q && bus.out_ready) begin
        s2_full_d = 1'b0;
      end
      if (s1_adv) begin
        s1_full_d = 1'b0;
        s2_full_d = 1'b1;
        y_d       = res;
        ovf_d     = res_ovf;
        if (mode_q == OP_ACC || mode_q == OP_LOAD) begin
          acc_d = res;
        end
      end
      if (accept) begin
        s1_full_d = 1'b1;
        a_d       = bus.a;
        b_d       = bus.b;
        mode_d    = op_e'(bus.mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    s1_full_q <= s1_full_d;
    a_q       <= a_d;
    b_q       <= b_d;
    mode_q    <= mode_d;
    s2_full_q <= s2_full_d;
    y_q       <= y_d;
    ovf_q     <= ovf_d;
    acc_q     <= acc_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_full_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;

endmodule
